// File: rtl/matrix_writeback.sv
// Write-back stage: takes 512-bit FFT result words and writes them into two 256-bit line-RAM banks.
// Optional macro WB_PARITY_EN adds per-lane even-parity outputs Par1_o/Par2_o.
module matrix_writeback #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned LINE_WORDS = 256,
    parameter int unsigned LINES      = 512,
    parameter int unsigned LINE_W     = 10
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              LVAL,
    input  logic [511:0]      D_i,
    input  logic              D_valid,
    output logic              D_ready,
    input  logic              RAM_Busy,
    output logic [ADDR_W-1:0] WrAddr,
    output logic              WrEn1,
    output logic              WrEn2,
    output logic [255:0]      D1_o,
    output logic [255:0]      D2_o,
    output logic [LINE_W-1:0] Line_o,
    output logic              Line_done,
    output logic              Line_err,
`ifdef WB_PARITY_EN
    output logic [7:0]        Par1_o,
    output logic [7:0]        Par2_o,
`endif
    output logic              Frame_done
);

    localparam int unsigned       CNT_W       = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LINE_WORDS_C = CNT_W'(LINE_WORDS);
    localparam logic [LINE_W-1:0] LAST_LINE    = LINE_W'(LINES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLine,
        StFlush,
        StEnd
    } state_e;

    state_e state_q, state_d;

    logic              lval_q;
    logic              lval_rise;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [LINE_W-1:0] line_q, line_d;

    // 2-entry skid FIFO
    logic [511:0] fifo_mem_q [2];
    logic         fifo_rd_q;
    logic         fifo_wr_q;
    logic [1:0]   fifo_cnt_q, fifo_cnt_d;
    logic         fifo_empty;
    logic         fifo_full;

    logic         push;
    logic         pop;
    logic         store;
    logic         deq;
    logic [511:0] pop_word;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [255:0]      d1_q, d2_q;

    assign lval_rise  = LVAL && !lval_q;
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign fifo_full  = (fifo_cnt_q == 2'd2);

    assign D_ready = (state_q == StLine) && LVAL && !fifo_full && (acc_cnt_q < LINE_WORDS_C);
    assign push    = D_valid && D_ready;

    // An empty FIFO lets the incoming word fall straight through to the write registers.
    assign pop      = (!fifo_empty || push) && !RAM_Busy;
    assign store    = push && !(fifo_empty && pop);
    assign deq      = pop && !fifo_empty;
    assign pop_word = fifo_empty ? D_i : fifo_mem_q[fifo_rd_q];

    assign fifo_cnt_d = fifo_cnt_q + {1'b0, store} - {1'b0, deq};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (lval_rise) begin
                    state_d = StLine;
                end
            end
            StLine: begin
                if (wr_cnt_q == LINE_WORDS_C) begin
                    state_d = StEnd;
                end else if (!LVAL && (acc_cnt_q < LINE_WORDS_C)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (fifo_empty && (wr_cnt_q == acc_cnt_q)) begin
                    state_d = StEnd;
                end
            end
            StEnd: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        acc_cnt_d = acc_cnt_q + CNT_W'(push);
        wr_cnt_d  = wr_cnt_q + CNT_W'(pop);
        line_d    = line_q;
        if (state_q == StEnd) begin
            acc_cnt_d = '0;
            wr_cnt_d  = '0;
            line_d    = (line_q == LAST_LINE) ? '0 : line_q + LINE_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            // Treat LVAL as already high so a level held through reset is not taken as a rise.
            lval_q    <= 1'b1;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            line_q    <= '0;
        end else begin
            state_q   <= state_d;
            lval_q    <= LVAL;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            line_q    <= line_d;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_rd_q     <= 1'b0;
            fifo_wr_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (store) begin
                fifo_mem_q[fifo_wr_q] <= D_i;
                fifo_wr_q             <= ~fifo_wr_q;
            end
            if (deq) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
        end else begin
            wr_en_q <= pop;
            if (pop) begin
                wr_addr_q <= wr_cnt_q[ADDR_W-1:0];
                d1_q      <= pop_word[511:256];
                d2_q      <= pop_word[255:0];
            end else if (state_q == StEnd) begin
                wr_addr_q <= '0;
            end
        end
    end

`ifdef WB_PARITY_EN
    logic [7:0] par1_d, par2_d;
    logic [7:0] par1_q, par2_q;

    always_comb begin
        par1_d = '0;
        par2_d = '0;
        for (int j = 0; j < 8; j++) begin
            par1_d[j] = ^pop_word[511-32*j -: 32];
            par2_d[j] = ^pop_word[255-32*j -: 32];
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            par1_q <= '0;
            par2_q <= '0;
        end else if (pop) begin
            par1_q <= par1_d;
            par2_q <= par2_d;
        end
    end

    assign Par1_o = par1_q;
    assign Par2_o = par2_q;
`endif

    assign WrEn1      = wr_en_q;
    assign WrEn2      = wr_en_q;
    assign WrAddr     = wr_addr_q;
    assign D1_o       = d1_q;
    assign D2_o       = d2_q;
    assign Line_o     = line_q;
    assign Line_done  = (state_q == StEnd);
    assign Line_err   = (state_q == StEnd) && (wr_cnt_q != LINE_WORDS_C);
    assign Frame_done = (state_q == StEnd) && (line_q == LAST_LINE);

endmodule

// File: tb/tb_matrix_writeback.sv
// Directed bench for matrix_writeback with LINE_WORDS=4, LINES=2.
module tb_matrix_writeback;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINES      = 2;
    localparam int unsigned LINE_W     = 1;

    logic              CLK = 1'b0;
    logic              Reset_n = 1'b0;
    logic              LVAL = 1'b0;
    logic [511:0]      D_i;
    logic              D_valid = 1'b0;
    logic              D_ready;
    logic              RAM_Busy = 1'b0;
    logic [ADDR_W-1:0] WrAddr;
    logic              WrEn1, WrEn2;
    logic [255:0]      D1_o, D2_o;
    logic [LINE_W-1:0] Line_o;
    logic              Line_done, Line_err, Frame_done;
`ifdef WB_PARITY_EN
    logic [7:0]        Par1_o, Par2_o;
`endif

    matrix_writeback #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS),
        .LINES      (LINES),
        .LINE_W     (LINE_W)
    ) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .LVAL       (LVAL),
        .D_i        (D_i),
        .D_valid    (D_valid),
        .D_ready    (D_ready),
        .RAM_Busy   (RAM_Busy),
        .WrAddr     (WrAddr),
        .WrEn1      (WrEn1),
        .WrEn2      (WrEn2),
        .D1_o       (D1_o),
        .D2_o       (D2_o),
        .Line_o     (Line_o),
        .Line_done  (Line_done),
        .Line_err   (Line_err),
`ifdef WB_PARITY_EN
        .Par1_o     (Par1_o),
        .Par2_o     (Par2_o),
`endif
        .Frame_done (Frame_done)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_total = 0;
    int exp_line = 0;
    logic         use_custom = 1'b0;
    logic [511:0] custom_word = '0;

    // Word n carries lane k = 3F800000 + n*256 + k, so order and lane placement are both visible.
    function automatic logic [511:0] make_word(input int n);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) begin
            w[511-32*k -: 32] = 32'h3F80_0000 + 32'(n * 256) + 32'(k);
        end
        return w;
    endfunction

    assign D_i = use_custom ? custom_word : make_word(acc_total);

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (D_valid && D_ready) acc_total <= acc_total + 1;
    end

    int           wa_log[$];
    int           cyc_log[$];
    bit           both_log[$];
    logic [255:0] d1_log[$];
    logic [255:0] d2_log[$];
    int           acc_cyc_log[$];
    bit           err_log[$];
    bit           frm_log[$];
    int           line_log[$];
`ifdef WB_PARITY_EN
    logic [7:0]   p1_log[$];
    logic [7:0]   p2_log[$];
`endif

    always @(negedge CLK) begin
        if (D_valid && D_ready) acc_cyc_log.push_back(cyc);
        if (WrEn1 || WrEn2) begin
            wa_log.push_back(int'(WrAddr));
            cyc_log.push_back(cyc);
            both_log.push_back(WrEn1 && WrEn2);
            d1_log.push_back(D1_o);
            d2_log.push_back(D2_o);
`ifdef WB_PARITY_EN
            p1_log.push_back(Par1_o);
            p2_log.push_back(Par2_o);
`endif
        end
        if (Line_done) begin
            err_log.push_back(Line_err);
            frm_log.push_back(Frame_done);
            line_log.push_back(int'(Line_o));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        wa_log.delete();
        cyc_log.delete();
        both_log.delete();
        d1_log.delete();
        d2_log.delete();
        acc_cyc_log.delete();
        err_log.delete();
        frm_log.delete();
        line_log.delete();
`ifdef WB_PARITY_EN
        p1_log.delete();
        p2_log.delete();
`endif
    endtask

    // Drives one full line and waits (bounded) for Line_done.
    task automatic run_line(output bit timeout);
        @(posedge CLK); #1;
        LVAL = 1'b1;
        D_valid = 1'b1;
        timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Line_done) begin
                timeout = 1'b0;
                break;
            end
        end
        @(posedge CLK); #1;
        LVAL = 1'b0;
        D_valid = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        LVAL = 1'b1;
        D_valid = 1'b1;
        #12;
        checks++;
        if ({WrEn1, WrEn2, Line_done, Line_err, Frame_done, D_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl actual=%b required=000000",
                     {WrEn1, WrEn2, Line_done, Line_err, Frame_done, D_ready});
        end
        checks++;
        if ({WrAddr, Line_o} !== '0) begin
            errors++;
            $display("FAIL reset_counters actual=%h/%h required=0/0", WrAddr, Line_o);
        end
        checks++;
        if ({D1_o, D2_o} !== 512'd0) begin
            errors++;
            $display("FAIL reset_data actual=%h_%h required=0", D1_o, D2_o);
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        repeat (4) begin @(posedge CLK); #1; end
        checks++;
        if (D_ready !== 1'b0 || wa_log.size() != 0) begin
            errors++;
            $display("FAIL lval_high_at_reset actual=ready%b,writes%0d required=ready0,writes0",
                     D_ready, wa_log.size());
        end
        LVAL = 1'b0;
        D_valid = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
    endtask

    task automatic test_full_line();
        bit to;
        int start;
        logic [511:0] w;
        clear_logs();
        start = acc_total;
        run_line(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL full_timeout actual=no_line_done required=line_done");
        end
        checks++;
        if (wa_log.size() != 4) begin
            errors++;
            $display("FAIL full_count actual=%0d required=4", wa_log.size());
        end
        for (int i = 0; i < wa_log.size() && i < 4; i++) begin
            w = make_word(start + i);
            checks++;
            if (wa_log[i] != i || !both_log[i] || cyc_log[i] != cyc_log[0] + i ||
                d1_log[i] !== w[511:256] || d2_log[i] !== w[255:0]) begin
                errors++;
                $display("FAIL full_write%0d actual=addr%0d,both%0b,dc%0d,d1=%h required=addr%0d,both1,dc%0d,d1=%h",
                         i, wa_log[i], both_log[i], cyc_log[i] - cyc_log[0], d1_log[i][255:224],
                         i, i, w[511:480]);
            end
        end
        if (wa_log.size() > 0) begin
            checks++;
            if (d1_log[0][255:224] !== 32'h3F80_0000 || d2_log[0][255:224] !== 32'h3F80_0008) begin
                errors++;
                $display("FAIL full_lane0 actual=%h/%h required=3f800000/3f800008",
                         d1_log[0][255:224], d2_log[0][255:224]);
            end
            checks++;
            if (acc_cyc_log.size() == 0 || cyc_log[0] != acc_cyc_log[0] + 1) begin
                errors++;
                $display("FAIL full_latency actual=write_cycle%0d required=accept_cycle+1",
                         cyc_log[0]);
            end
        end
        checks++;
        if (err_log.size() != 1 || err_log[0] != 1'b0 || line_log[0] != exp_line ||
            frm_log[0] != (exp_line == LINES - 1)) begin
            errors++;
            $display("FAIL full_done actual=n%0d required=n1,err0,line%0d", err_log.size(),
                     exp_line);
        end
        exp_line = (exp_line + 1) % LINES;
        checks++;
        if (int'(Line_o) !== exp_line) begin
            errors++;
            $display("FAIL full_line_o actual=%0d required=%0d", Line_o, exp_line);
        end
    endtask

    task automatic test_backpressure();
        int start;
        int n_acc;
        bit to;
        logic [ADDR_W-1:0] held_addr;
        logic [255:0] held_d1, held_d2;
        logic [511:0] w;
        clear_logs();
        start = acc_total;
        n_acc = 0;
        @(posedge CLK); #1;
        LVAL = 1'b1;
        D_valid = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RAM_Busy = 1'b1;
        held_addr = WrAddr;
        held_d1 = D1_o;
        held_d2 = D2_o;
        checks++;
        if (WrEn1 !== 1'b1 || WrAddr !== '0) begin
            errors++;
            $display("FAIL bp_first_write actual=en%b,addr%0d required=en1,addr0", WrEn1, WrAddr);
        end
        @(negedge CLK);
        if (D_valid && D_ready) n_acc++;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            if (i == 2) RAM_Busy = 1'b0;
            @(negedge CLK);
            if (i < 2 && D_valid && D_ready) n_acc++;
            if (i == 1) begin
                checks++;
                if (D_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready_drop actual=%b required=0", D_ready);
                end
            end
            checks++;
            if (WrEn1 !== 1'b0 || WrEn2 !== 1'b0 || WrAddr !== held_addr ||
                D1_o !== held_d1 || D2_o !== held_d2) begin
                errors++;
                $display("FAIL bp_hold%0d actual=en%b%b,addr%0d required=en00,addr%0d,data_held",
                         i, WrEn1, WrEn2, WrAddr, held_addr);
            end
        end
        checks++;
        if (n_acc != 2) begin
            errors++;
            $display("FAIL bp_accepted actual=%0d required=2", n_acc);
        end
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Line_done) begin
                to = 1'b0;
                break;
            end
        end
        @(posedge CLK); #1;
        LVAL = 1'b0;
        D_valid = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (to || wa_log.size() != 4) begin
            errors++;
            $display("FAIL bp_count actual=%0d,timeout%0b required=4,timeout0", wa_log.size(), to);
        end
        for (int i = 0; i < wa_log.size() && i < 4; i++) begin
            w = make_word(start + i);
            checks++;
            if (wa_log[i] != i || d1_log[i] !== w[511:256] || d2_log[i] !== w[255:0]) begin
                errors++;
                $display("FAIL bp_write%0d actual=addr%0d,d1=%h required=addr%0d,d1=%h",
                         i, wa_log[i], d1_log[i][255:224], i, w[511:480]);
            end
        end
        checks++;
        if (err_log.size() != 1 || err_log[0] != 1'b0 ||
            frm_log[0] != (exp_line == LINES - 1)) begin
            errors++;
            $display("FAIL bp_done actual=n%0d required=n1,err0,frame%0d", err_log.size(),
                     exp_line == LINES - 1);
        end
        exp_line = (exp_line + 1) % LINES;
        checks++;
        if (int'(Line_o) !== exp_line) begin
            errors++;
            $display("FAIL bp_line_o actual=%0d required=%0d", Line_o, exp_line);
        end
    endtask

    task automatic test_frame_wrap();
        bit to0, to1;
        clear_logs();
        run_line(to0);
        run_line(to1);
        checks++;
        if (to0 || to1 || frm_log.size() != 2) begin
            errors++;
            $display("FAIL wrap_count actual=%0d required=2", frm_log.size());
        end else begin
            checks++;
            if (frm_log[0] != 1'b0 || frm_log[1] != 1'b1 || line_log[0] != 0 || line_log[1] != 1 ||
                err_log[0] || err_log[1]) begin
                errors++;
                $display("FAIL wrap_frame actual=frame%0b%0b,line%0d%0d required=frame01,line01",
                         frm_log[0], frm_log[1], line_log[0], line_log[1]);
            end
        end
        checks++;
        if (Line_o !== '0) begin
            errors++;
            $display("FAIL wrap_line_o actual=%0d required=0", Line_o);
        end
        exp_line = 0;
    endtask

    task automatic test_short_line();
        int start;
        bit to;
        logic [511:0] w;
        clear_logs();
        start = acc_total;
        @(posedge CLK); #1;
        LVAL = 1'b1;
        D_valid = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        LVAL = 1'b0;
        D_valid = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Line_done) begin
                to = 1'b0;
                break;
            end
        end
        @(posedge CLK); #1;
        checks++;
        if (to || wa_log.size() != 2) begin
            errors++;
            $display("FAIL short_count actual=%0d required=2", wa_log.size());
        end
        for (int i = 0; i < wa_log.size() && i < 2; i++) begin
            w = make_word(start + i);
            checks++;
            if (wa_log[i] != i || d1_log[i] !== w[511:256]) begin
                errors++;
                $display("FAIL short_write%0d actual=addr%0d required=addr%0d", i, wa_log[i], i);
            end
        end
        checks++;
        if (err_log.size() != 1 || err_log[0] != 1'b1 || frm_log[0] != 1'b0) begin
            errors++;
            $display("FAIL short_err actual=n%0d required=n1,err1,frame0", err_log.size());
        end
        checks++;
        if (WrAddr !== '0) begin
            errors++;
            $display("FAIL short_addr_wrap actual=%0d required=0", WrAddr);
        end
        exp_line = (exp_line + 1) % LINES;
    endtask

    task automatic test_async_reset();
        int start;
        bit to;
        logic [511:0] w;
        clear_logs();
        @(posedge CLK); #1;
        RAM_Busy = 1'b1;
        LVAL = 1'b1;
        D_valid = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        D_valid = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({WrEn1, WrEn2, D_ready, Line_done} !== 4'b0 || {WrAddr, Line_o} !== '0 ||
            {D1_o, D2_o} !== 512'd0) begin
            errors++;
            $display("FAIL areset_outputs actual=en%b%b,rdy%b,addr%0d,line%0d,d1=%h required=all_zero",
                     WrEn1, WrEn2, D_ready, WrAddr, Line_o, D1_o[255:224]);
        end
        LVAL = 1'b0;
        RAM_Busy = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset_n = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        checks++;
        if (err_log.size() != 0 || wa_log.size() != 0) begin
            errors++;
            $display("FAIL areset_discard actual=done%0d,writes%0d required=done0,writes0",
                     err_log.size(), wa_log.size());
        end
        exp_line = 0;
        clear_logs();
        start = acc_total;
        run_line(to);
        w = make_word(start);
        checks++;
        if (to || wa_log.size() != 4 || line_log.size() != 1) begin
            errors++;
            $display("FAIL areset_fresh_count actual=%0d required=4", wa_log.size());
        end else begin
            checks++;
            if (wa_log[0] != 0 || d1_log[0] !== w[511:256] || line_log[0] != 0) begin
                errors++;
                $display("FAIL areset_fresh actual=addr%0d,line%0d required=addr0,line0",
                         wa_log[0], line_log[0]);
            end
        end
        exp_line = (exp_line + 1) % LINES;
    endtask

`ifdef WB_PARITY_EN
    task automatic test_parity();
        bit to;
        clear_logs();
        custom_word = '0;
        custom_word[511:480] = 32'h0000_0001;
        custom_word[479:448] = 32'h0000_0003;
        use_custom = 1'b1;
        run_line(to);
        use_custom = 1'b0;
        checks++;
        if (to || p1_log.size() == 0) begin
            errors++;
            $display("FAIL parity_count actual=%0d required=4", p1_log.size());
        end else begin
            checks++;
            if (p1_log[0] !== 8'h01 || p2_log[0] !== 8'h00) begin
                errors++;
                $display("FAIL parity_value actual=%h/%h required=01/00", p1_log[0], p2_log[0]);
            end
        end
        exp_line = (exp_line + 1) % LINES;
    endtask
`endif

    initial begin
        test_reset();
        test_full_line();
        test_backpressure();
        test_frame_wrap();
        test_short_line();
        test_async_reset();
`ifdef WB_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matrix_writeback.md
Name: matrix_writeback

Overview:
- Write-back end of the FFT transfer-matrix path: accepts 512-bit result words (16 lanes x 32-bit float) and writes them into the two 256-bit line-RAM banks that feed the transfer-matrix adder stage.
- Generates the bank addresses, line/frame counters and write strobes.
- Absorbs RAM back-pressure through a 2-entry skid FIFO.

Parameters:
ADDR_W, 9, word-address width of each RAM bank
LINE_WORDS, 256, words per line; must be <= 2**ADDR_W and >= 2
LINES, 512, lines per frame
LINE_W, 10, width of line counter; must satisfy 2**LINE_W >= LINES

Ports:
CLK  in  1  single clock, all logic rising-edge
Reset_n  in  1  asynchronous, active-low reset
LVAL  in  1  line valid; high for the duration of one line
D_i  in  512  result word; lane k at bits [511-32k -: 32]
D_valid  in  1  D_i valid this cycle
D_ready  out  1  block can accept D_i this cycle
RAM_Busy  in  1  RAM write port stalled; no write may issue
WrAddr  out  ADDR_W  word address within line, shared by both banks
WrEn1  out  1  bank-1 write strobe
WrEn2  out  1  bank-2 write strobe
D1_o  out  256  lanes 0-7, lane 0 in MSBs
D2_o  out  256  lanes 8-15, lane 8 in MSBs
Line_o  out  LINE_W  current line index
Line_done  out  1  one-cycle pulse at end of each line
Line_err  out  1  one-cycle pulse with Line_done when the line was short
Frame_done  out  1  one-cycle pulse with Line_done of last line

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, all counters 0. All outputs 0, including D_ready, WrEn1/2, WrAddr, D1_o/D2_o, Line_o and the pulses. A partial line in progress is discarded and no Line_done is issued.
- Acceptance: a word is taken when D_valid && D_ready.
  - D_ready = (state==LINE) && LVAL && !fifo_full && (accepted count < LINE_WORDS).
  - D_ready is combinational from registered state plus LVAL.
- Write issue: when the FIFO is non-empty and RAM_Busy is low, pop one word and register it into D1_o/D2_o with WrAddr = write count. WrEn1 = WrEn2 = 1 for exactly that cycle.
  - All write outputs are registered.
  - Latency: a word accepted at cycle t into an empty FIFO appears with WrEn high at t+1.
- RAM_Busy high: WrEn1/2 are 0; D1_o, D2_o and WrAddr hold their last values.
- Simultaneous push and pop: FIFO count is unchanged. Push when full is impossible because D_ready is low.
- States:
  - IDLE -> LINE on a rising edge of LVAL (registered edge detect). LVAL already high coming out of reset does not start a line.
  - LINE -> END when write count reaches LINE_WORDS.
  - LINE -> FLUSH when LVAL is low and accepted count < LINE_WORDS.
  - FLUSH -> END when the FIFO is empty and all accepted words are written. No new words are accepted in FLUSH.
  - END, one cycle:
    - Pulse Line_done. Pulse Line_err if write count != LINE_WORDS.
    - Pulse Frame_done if Line_o == LINES-1.
    - Clear the write/accepted counters (WrAddr wraps to 0). Increment Line_o, wrapping LINES-1 -> 0.
    - Then -> IDLE.
- LVAL still high after a full line: ignored. The next line requires LVAL to fall and rise again.
- A word presented while LVAL is low or in IDLE/END is not accepted and is not an error.
- Counter widths: accepted/write counters are ADDR_W+1 bits, so no wrap occurs before the compare.

Optional Feature:
- Macro WB_PARITY_EN.
- Defined: adds outputs Par1_o[7:0] and Par2_o[7:0]. Bit j is the even parity (XOR reduction) of lane j (Par1) or lane 8+j (Par2) of the written word. They are registered alongside D1_o/D2_o, so they carry identical latency and hold behaviour, and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Full line, LINE_WORDS=4, RAM_Busy=0, D_valid held high with lane k = 32'h3F800000+k -> WrEn1/2 high on 4 consecutive cycles, WrAddr 0,1,2,3. D1_o[255:224]=32'h3F800000 and D2_o[255:224]=32'h3F800008. Line_done pulse, Line_err=0, Line_o 0->1.
- Back-pressure: RAM_Busy high for 3 cycles mid-line -> D_ready drops after 2 accepted words, no WrEn while busy, outputs held. After release, the remaining words are written in order with no loss or duplicate.
- Short line: LVAL falls after 2 of 4 words -> FIFO drains, 2 writes at WrAddr 0,1, Line_done and Line_err pulse together, next line starts at WrAddr 0.
- Frame wrap, LINES=2: run 2 full lines -> Frame_done on the second Line_done, Line_o returns to 0.
- Async reset asserted mid-line with FIFO holding 1 word -> all outputs 0 immediately, no Line_done. After release, a fresh line writes from WrAddr 0 with Line_o=0.
- WB_PARITY_EN defined, lane 0 = 32'h00000001, lane 1 = 32'h00000003 -> Par1_o[0]=1, Par1_o[1]=0, valid in the same cycle as WrEn1.
